gpu_wb_slave_bridge: RTL and testbench
======================================

# gpu_wb_slave_bridge

Parametrised Wishbone classic slave that sits between the host bus and the GPU's register and memory blocks (control registers, sprite memory, tile map, texture memory). It decodes a region field of the address into one-hot write/read strobes, paces accesses to a programmable clock-enable ratio, returns read data from per-region ports with a configurable latency, and terminates every cycle with a single-cycle acknowledge. It replaces the fixed, write-only, divide-by-two decode.

## Interface
- ADDR_W, 27, Wishbone address width
- DATA_W, 32, data width; a multiple of 8
- N_REGIONS, 4, number of decoded target regions; 1..16
- REGION_LSB, 12, LSB of the region-select field in wb_adr_i
- REGION_W, 4, width of the region-select field; 2^REGION_W >= N_REGIONS
- RD_LATENCY, 1, cycles from o_region_re to valid i_region_rdata; 1..4
- PACE_DIV, 2, issue-slot period in clocks; 1..8 (1 means every cycle)

Ports:
- clk_100MHz  in  1  system clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, and write qualifiers
- wb_sel_i  in  DATA_W/8  byte selects
- wb_adr_i  in  ADDR_W  address
- wb_dat_i  in  DATA_W  write data
- wb_dat_o  out  DATA_W  read data; valid only while wb_ack_o is high
- wb_ack_o  out  1  single-cycle acknowledge
- wb_err_o  out  1  error termination; present only with GPU_WB_ERR_EN
- o_region_we, o_region_re  out  N_REGIONS each  one-hot, single-cycle write/read strobes
- o_addr  out  ADDR_W  latched address, region field included
- o_wdata  out  DATA_W  latched write data
- o_wsel  out  DATA_W/8  latched byte selects
- i_region_rdata  in  N_REGIONS*DATA_W  read data; region k occupies bits [k*DATA_W +: DATA_W]
- o_busy  out  1  high whenever the state is not IDLE

## Operation
- Region index r = wb_adr_i[REGION_LSB +: REGION_W]. The address is mapped when r < N_REGIONS.
- Pace counter: free-running, counts 0..PACE_DIV-1 and wraps. A slot is the cycle in which the counter equals 0.
- FSM states and transitions:
  - IDLE: on wb_cyc_i & wb_stb_i & slot, latch address, data, sel, we and r, then go to ISSUE.
  - ISSUE: if mapped, pulse o_region_we[r] or o_region_re[r] for exactly one cycle. A mapped write goes to ACK. A mapped read goes to WAIT. An unmapped access drives no strobe and goes to ACK.
  - WAIT: counts RD_LATENCY cycles, captures i_region_rdata slice r into wb_dat_o on the last count, then goes to ACK.
  - ACK: assert wb_ack_o (or wb_err_o, see Configuration) for one cycle, then go to IDLE.
- wb_dat_o is 0 on writes and on unmapped reads.
- Abort: if wb_cyc_i falls in ISSUE, WAIT or ACK, return to IDLE next cycle with no ack. A strobe already pulsed is not retracted.
- If wb_stb_i is still high in the cycle after ACK, it is a new request and waits for the next slot.
- Latched outputs (o_addr, o_wdata, o_wsel) hold their values until the next accepted request.

## Timing
- Reset (asynchronous assert): all outputs 0, state IDLE, pace counter 0, all latches 0. The first slot is the first cycle after reset release.
- Request accepted at slot cycle T:
  - strobe at T+1
  - write ack at T+2
  - read ack at T+2+RD_LATENCY
- Worst-case added wait before acceptance is PACE_DIV-1 cycles.
- At most one transaction is outstanding; no pipelining.
- Reset mid-transaction: outputs clear immediately and no ack is produced.

## Configuration
- GPU_WB_ERR_EN defined: wb_err_o exists. Unmapped accesses terminate with wb_err_o high for one cycle and wb_ack_o low.
- GPU_WB_ERR_EN undefined: wb_err_o is absent. Unmapped writes are silently dropped with ack; unmapped reads ack with wb_dat_o = 0.

## Structure
- Shared package gpu_wb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACK)
  - the region index constants for the control registers, sprite memory, tile map and texture memory (0..3)
  - a clog2-style helper for the counter widths
- One sub-module, gpu_wb_pace_counter, generates the slot pulse; it takes parameter PACE_DIV.

## Test plan
- Defaults, write adr 0x0001004, dat 0xDEADBEEF, sel 0xF at a slot cycle T -> o_region_we = 4'b0010 at T+1 only, o_addr = 0x0001004, wb_ack_o at T+2, exactly one ack.
- Read region 3 with RD_LATENCY = 3, i_region_rdata slice 3 = 0x12345678 -> o_region_re = 4'b1000 at T+1, ack at T+5, wb_dat_o = 0x12345678 only in the ack cycle.
- PACE_DIV = 4, stb raised one cycle after a slot -> acceptance 3 cycles later, o_busy high from the following cycle.
- Unmapped region 5 read, with and without GPU_WB_ERR_EN -> without: ack with dat 0 and no strobes; with: wb_err_o one cycle and no ack.
- wb_cyc_i dropped during WAIT -> no ack or err, IDLE next cycle, next request served normally.
- wb_rst_i asserted mid-WAIT asynchronously -> all outputs 0 within the same cycle; after release, a back-to-back write gets ack at T+2.

Source files
------------

// File: rtl/gpu_wb_pkg.sv
// Shared types and constants for the GPU Wishbone slave bridge.
// Optional error termination is enabled by defining GPU_WB_ERR_EN.
package gpu_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } gpu_wb_state_e;

  localparam int REGION_CTRL    = 0;
  localparam int REGION_SPRITE  = 1;
  localparam int REGION_TILEMAP = 2;
  localparam int REGION_TEXTURE = 3;

  // Counter width for a range of `value` states; never less than one bit.
  function automatic int gpu_wb_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/gpu_wb_pace_counter.sv
// Free-running issue-slot generator: slot is high when the counter is at zero.
// Counts 0..PACE_DIV-1 and wraps; the first cycle after reset is a slot.
module gpu_wb_pace_counter
  import gpu_wb_pkg::*;
#(
  parameter int PACE_DIV = 2
) (
  input  logic clk_100MHz,
  input  logic wb_rst_i,
  output logic slot
);

  localparam int CNT_W = gpu_wb_clog2(PACE_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(PACE_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot = (cnt == '0);

endmodule

// File: rtl/gpu_wb_slave_bridge.sv
// Wishbone classic slave decoding an address region field into per-region strobes.
// Define GPU_WB_ERR_EN to terminate unmapped accesses with wb_err_o instead of wb_ack_o.
//
// state | meaning
// IDLE  | waiting for cyc & stb in a pace slot
// ISSUE | strobe for the latched region is high this cycle
// WAIT  | counting down read latency, capture data on terminal count
// ACK   | termination pulse is high this cycle
module gpu_wb_slave_bridge
  import gpu_wb_pkg::*;
#(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int N_REGIONS  = 4,
  parameter int REGION_LSB = 12,
  parameter int REGION_W   = 4,
  parameter int RD_LATENCY = 1,
  parameter int PACE_DIV   = 2
) (
  input  logic                        clk_100MHz,
  input  logic                        wb_rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [DATA_W/8-1:0]         wb_sel_i,
  input  logic [ADDR_W-1:0]           wb_adr_i,
  input  logic [DATA_W-1:0]           wb_dat_i,
  output logic [DATA_W-1:0]           wb_dat_o,
  output logic                        wb_ack_o,
`ifdef GPU_WB_ERR_EN
  output logic                        wb_err_o,
`endif
  output logic [N_REGIONS-1:0]        o_region_we,
  output logic [N_REGIONS-1:0]        o_region_re,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W-1:0]           o_wdata,
  output logic [DATA_W/8-1:0]         o_wsel,
  input  logic [N_REGIONS*DATA_W-1:0] i_region_rdata,
  output logic                        o_busy
);

  localparam int WAIT_W = gpu_wb_clog2(RD_LATENCY);

  gpu_wb_state_e         state;
  logic                  slot;
  logic [REGION_W-1:0]   req_region;
  logic                  req_mapped;
  logic [REGION_W-1:0]   region_q;
  logic                  mapped_q;
  logic                  we_q;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_W-1:0]     rd_slice;
  logic [N_REGIONS-1:0]  req_onehot;

  gpu_wb_pace_counter #(
    .PACE_DIV(PACE_DIV)
  ) u_pace (
    .clk_100MHz(clk_100MHz),
    .wb_rst_i  (wb_rst_i),
    .slot      (slot)
  );

  assign req_region = wb_adr_i[REGION_LSB +: REGION_W];
  assign req_mapped = (32'(req_region) < N_REGIONS);
  assign req_onehot = req_mapped ? (N_REGIONS'(1) << req_region) : '0;
  assign o_busy     = (state != ST_IDLE);

  always_comb begin
    rd_slice = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      if (32'(region_q) == k) rd_slice = i_region_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      o_region_we <= '0;
      o_region_re <= '0;
      wb_ack_o    <= 1'b0;
`ifdef GPU_WB_ERR_EN
      wb_err_o    <= 1'b0;
`endif
      wb_dat_o    <= '0;
      o_addr      <= '0;
      o_wdata     <= '0;
      o_wsel      <= '0;
      region_q    <= '0;
      mapped_q    <= 1'b0;
      we_q        <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      o_region_we <= '0;
      o_region_re <= '0;
      wb_ack_o    <= 1'b0;
`ifdef GPU_WB_ERR_EN
      wb_err_o    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i && slot) begin
            o_addr   <= wb_adr_i;
            o_wdata  <= wb_dat_i;
            o_wsel   <= wb_sel_i;
            region_q <= req_region;
            mapped_q <= req_mapped;
            we_q     <= wb_we_i;
            // Strobe registered here so it is high exactly during ISSUE.
            if (wb_we_i) o_region_we <= req_onehot;
            else         o_region_re <= req_onehot;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (mapped_q && !we_q) begin
            wait_cnt <= WAIT_W'(RD_LATENCY - 1);
            state    <= ST_WAIT;
          end else begin
`ifdef GPU_WB_ERR_EN
            if (mapped_q) wb_ack_o <= 1'b1;
            else          wb_err_o <= 1'b1;
`else
            wb_ack_o <= 1'b1;
`endif
            state <= ST_ACK;
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (wait_cnt == '0) begin
            wb_dat_o <= rd_slice;
            wb_ack_o <= 1'b1;
            state    <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          wb_dat_o <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_wb_slave_bridge.sv
// Directed bench for gpu_wb_slave_bridge with RD_LATENCY=3, PACE_DIV=4.
// Builds with or without GPU_WB_ERR_EN.
module tb_gpu_wb_slave_bridge;

  logic         clk_100MHz = 1'b0;
  logic         wb_rst_i;
  logic         wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]   wb_sel_i;
  logic [26:0]  wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [31:0]  wb_dat_o;
  logic         wb_ack_o;
  logic         wb_err_o;
  logic [3:0]   o_region_we, o_region_re;
  logic [26:0]  o_addr;
  logic [31:0]  o_wdata;
  logic [3:0]   o_wsel;
  logic [127:0] i_region_rdata;
  logic         o_busy;

  int tests = 0;
  int fails = 0;
  int pace;

  always #5 clk_100MHz = ~clk_100MHz;

`ifndef GPU_WB_ERR_EN
  assign wb_err_o = 1'b0;
`endif

  gpu_wb_slave_bridge #(
    .RD_LATENCY(3),
    .PACE_DIV  (4)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .wb_rst_i      (wb_rst_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_sel_i      (wb_sel_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
`ifdef GPU_WB_ERR_EN
    .wb_err_o      (wb_err_o),
`endif
    .o_region_we   (o_region_we),
    .o_region_re   (o_region_re),
    .o_addr        (o_addr),
    .o_wdata       (o_wdata),
    .o_wsel        (o_wsel),
    .i_region_rdata(i_region_rdata),
    .o_busy        (o_busy)
  );

  // Reference slot phase: 0 in the first cycle after reset, period 4.
  always @(posedge clk_100MHz or posedge wb_rst_i) begin
    if (wb_rst_i) pace <= 0;
    else          pace <= (pace == 3) ? 0 : pace + 1;
  end

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0;   wb_dat_i = '0;   wb_sel_i = '0;
  endtask

  task automatic req(input logic w, input logic [26:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
    wb_adr_i = a;    wb_dat_i = d;    wb_sel_i = s;
  endtask

  task automatic wait_pace(input int p);
    int n = 0;
    while (pace != p && n < 8) begin
      @(negedge clk_100MHz);
      n++;
    end
    tests++;
    if (pace != p) begin
      $display("FAIL wait_pace: phase %0d required %0d", pace, p);
      fails++;
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({wb_ack_o, wb_err_o, o_busy, o_region_we, o_region_re} !== 11'd0) begin
      $display("FAIL reset_ctrl: ack/err/busy/we/re=%b required 0", {wb_ack_o, wb_err_o, o_busy, o_region_we, o_region_re});
      fails++;
    end
    tests++;
    if ({wb_dat_o, o_addr, o_wdata, o_wsel} !== 95'd0) begin
      $display("FAIL reset_data: dat=%h addr=%h wdata=%h wsel=%h required 0", wb_dat_o, o_addr, o_wdata, o_wsel);
      fails++;
    end
  endtask

  task automatic test_write();
    int acks = 0;
    wait_pace(0);
    req(1'b1, 27'h0001004, 32'hDEADBEEF, 4'hF);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_we !== 4'b0010 || o_region_re !== 4'b0000) begin
      $display("FAIL wr_strobe: we=%b re=%b required we=0010 re=0000", o_region_we, o_region_re);
      fails++;
    end
    tests++;
    if (o_addr !== 27'h0001004 || o_wdata !== 32'hDEADBEEF || o_wsel !== 4'hF) begin
      $display("FAIL wr_latch: addr=%h wdata=%h wsel=%h required 0001004 deadbeef f", o_addr, o_wdata, o_wsel);
      fails++;
    end
    tests++;
    if (wb_ack_o !== 1'b0 || o_busy !== 1'b1) begin
      $display("FAIL wr_t1: ack=%b busy=%b required ack=0 busy=1", wb_ack_o, o_busy);
      fails++;
    end
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b1 || o_region_we !== 4'b0000 || wb_dat_o !== 32'h0) begin
      $display("FAIL wr_ack: ack=%b we=%b dat=%h required ack=1 we=0000 dat=0", wb_ack_o, o_region_we, wb_dat_o);
      fails++;
    end
    idle_bus();
    repeat (4) begin
      @(negedge clk_100MHz);
      acks += int'(wb_ack_o) + int'(o_region_we != 4'b0000);
    end
    tests++;
    if (acks != 0) begin
      $display("FAIL wr_single_ack: extra ack/strobe cycles=%0d required 0", acks);
      fails++;
    end
    tests++;
    if (o_busy !== 1'b0 || o_addr !== 27'h0001004 || o_wdata !== 32'hDEADBEEF) begin
      $display("FAIL wr_hold: busy=%b addr=%h wdata=%h required 0 0001004 deadbeef", o_busy, o_addr, o_wdata);
      fails++;
    end
  endtask

  task automatic test_read();
    wait_pace(0);
    req(1'b0, 27'h0003000, 32'h0, 4'hF);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_re !== 4'b1000 || o_region_we !== 4'b0000) begin
      $display("FAIL rd_strobe: re=%b we=%b required re=1000 we=0000", o_region_re, o_region_we);
      fails++;
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk_100MHz);
      tests++;
      if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || o_region_re !== 4'b0000) begin
        $display("FAIL rd_wait_t%0d: ack=%b dat=%h re=%b required 0 0 0000", k, wb_ack_o, wb_dat_o, o_region_re);
        fails++;
      end
    end
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h12345678) begin
      $display("FAIL rd_ack: ack=%b dat=%h required ack=1 dat=12345678", wb_ack_o, wb_dat_o);
      fails++;
    end
    idle_bus();
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      $display("FAIL rd_after: ack=%b dat=%h required 0 0", wb_ack_o, wb_dat_o);
      fails++;
    end
  endtask

  task automatic test_pace();
    wait_pace(1);
    req(1'b1, 27'h0000010, 32'h000000A5, 4'h1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_100MHz);
      tests++;
      if (o_busy !== 1'b0 || o_region_we !== 4'b0000) begin
        $display("FAIL pace_hold_%0d: busy=%b we=%b required 0 0000", k, o_busy, o_region_we);
        fails++;
      end
    end
    @(negedge clk_100MHz);
    tests++;
    if (o_busy !== 1'b1 || o_region_we !== 4'b0001) begin
      $display("FAIL pace_accept: busy=%b we=%b required 1 0001", o_busy, o_region_we);
      fails++;
    end
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b1) begin
      $display("FAIL pace_ack: ack=%b required 1", wb_ack_o);
      fails++;
    end
    idle_bus();
    @(negedge clk_100MHz);
  endtask

  task automatic test_unmapped();
    wait_pace(0);
    req(1'b0, 27'h0005000, 32'h0, 4'hF);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_we !== 4'b0000 || o_region_re !== 4'b0000 || o_busy !== 1'b1) begin
      $display("FAIL unmap_strobe: we=%b re=%b busy=%b required 0000 0000 1", o_region_we, o_region_re, o_busy);
      fails++;
    end
    @(negedge clk_100MHz);
`ifdef GPU_WB_ERR_EN
    tests++;
    if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0) begin
      $display("FAIL unmap_err: err=%b ack=%b required err=1 ack=0", wb_err_o, wb_ack_o);
      fails++;
    end
`else
    tests++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0) begin
      $display("FAIL unmap_ack: ack=%b dat=%h required ack=1 dat=0", wb_ack_o, wb_dat_o);
      fails++;
    end
`endif
    idle_bus();
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL unmap_after: ack=%b err=%b busy=%b required 0 0 0", wb_ack_o, wb_err_o, o_busy);
      fails++;
    end
  endtask

  task automatic test_abort();
    int terms = 0;
    wait_pace(0);
    req(1'b0, 27'h0002000, 32'h0, 4'hF);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_re !== 4'b0100) begin
      $display("FAIL abort_strobe: re=%b required 0100", o_region_re);
      fails++;
    end
    @(negedge clk_100MHz);
    idle_bus();
    @(negedge clk_100MHz);
    tests++;
    if (o_busy !== 1'b0) begin
      $display("FAIL abort_idle: busy=%b required 0", o_busy);
      fails++;
    end
    repeat (4) begin
      @(negedge clk_100MHz);
      terms += int'(wb_ack_o) + int'(wb_err_o);
    end
    tests++;
    if (terms != 0) begin
      $display("FAIL abort_noack: termination cycles=%0d required 0", terms);
      fails++;
    end
    wait_pace(0);
    req(1'b1, 27'h0001008, 32'h0BADF00D, 4'h3);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_we !== 4'b0010 || o_wdata !== 32'h0BADF00D || o_wsel !== 4'h3) begin
      $display("FAIL abort_next_wr: we=%b wdata=%h wsel=%h required 0010 0badf00d 3", o_region_we, o_wdata, o_wsel);
      fails++;
    end
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b1) begin
      $display("FAIL abort_next_ack: ack=%b required 1", wb_ack_o);
      fails++;
    end
    idle_bus();
    @(negedge clk_100MHz);
  endtask

  task automatic test_reset_mid();
    wait_pace(0);
    req(1'b0, 27'h0001000, 32'hFFFF0000, 4'hF);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_re !== 4'b0010) begin
      $display("FAIL rstmid_strobe: re=%b required 0010", o_region_re);
      fails++;
    end
    @(negedge clk_100MHz);
    wb_rst_i = 1'b1;
    #1;
    tests++;
    if ({wb_ack_o, wb_err_o, o_busy, o_region_we, o_region_re} !== 11'd0 ||
        {wb_dat_o, o_addr, o_wdata, o_wsel} !== 95'd0) begin
      $display("FAIL rstmid_clear: ctrl=%b addr=%h wdata=%h wsel=%h dat=%h required all 0",
               {wb_ack_o, wb_err_o, o_busy, o_region_we, o_region_re}, o_addr, o_wdata, o_wsel, wb_dat_o);
      fails++;
    end
    idle_bus();
    @(negedge clk_100MHz);
    wb_rst_i = 1'b0;
    req(1'b1, 27'h0003004, 32'h55AA55AA, 4'hC);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_we !== 4'b1000 || o_addr !== 27'h0003004) begin
      $display("FAIL rstmid_wr1_strobe: we=%b addr=%h required 1000 0003004", o_region_we, o_addr);
      fails++;
    end
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b1) begin
      $display("FAIL rstmid_wr1_ack: ack=%b required 1", wb_ack_o);
      fails++;
    end
    idle_bus();
    wait_pace(0);
    req(1'b1, 27'h0000008, 32'h01020304, 4'hF);
    @(negedge clk_100MHz);
    tests++;
    if (o_region_we !== 4'b0001 || wb_ack_o !== 1'b0) begin
      $display("FAIL rstmid_wr2_t1: we=%b ack=%b required 0001 0", o_region_we, wb_ack_o);
      fails++;
    end
    @(negedge clk_100MHz);
    tests++;
    if (wb_ack_o !== 1'b1) begin
      $display("FAIL rstmid_wr2_ack: ack=%b required 1", wb_ack_o);
      fails++;
    end
    idle_bus();
    @(negedge clk_100MHz);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    idle_bus();
    i_region_rdata = {32'h12345678, 32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
    repeat (3) @(negedge clk_100MHz);
    test_reset();
    @(negedge clk_100MHz);
    wb_rst_i = 1'b0;
    test_write();
    test_read();
    test_pace();
    test_unmapped();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
